// File: rtl/gray_track.sv
// Registers a Gray-coded sample stream, decodes it to binary and tracks unit steps.
// Each accepted sample is classified as up, down, hold or illegal jump against the previous one.
module gray_track #(
  parameter int W     = 4,
  parameter int POS_W = 16,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     gray_in,
  input  logic             in_valid,
  input  logic             clear,
  output logic [W-1:0]     bin_out,
  output logic             out_valid,
  output logic             step_up,
  output logic             step_dn,
  output logic             err,
  output logic             primed,
  output logic [POS_W-1:0] position,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic {UNPRIMED = 1'b0, TRACK = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       bin_q, bin_d;
  logic               out_valid_q, out_valid_d;
  logic               step_up_q, step_up_d;
  logic               step_dn_q, step_dn_d;
  logic               err_q, err_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

  logic [W-1:0]       dec;
  logic [W-1:0]       delta;

  assign dec[W-1] = gray_in[W-1];
  genvar gi;
  generate
    for (gi = W - 2; gi >= 0; gi--) begin : g_decode
      assign dec[gi] = dec[gi+1] ^ gray_in[gi];
    end
  endgenerate

  // bin_q doubles as the previous-sample reference for the delta check.
  assign delta = dec - bin_q;

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    out_valid_d = 1'b0;
    step_up_d   = 1'b0;
    step_dn_d   = 1'b0;
    err_d       = 1'b0;
    pos_d       = pos_q;
    err_cnt_d   = err_cnt_q;

    if (in_valid) begin
      bin_d       = dec;
      out_valid_d = 1'b1;
      if (state_q == TRACK) begin
        step_up_d = (delta == W'(1));
        step_dn_d = (delta == {W{1'b1}});
        err_d     = (delta != '0) && (delta != W'(1)) && (delta != {W{1'b1}});
      end
      state_d = TRACK;
    end

    // Clear takes priority over any step/error counted in the same cycle.
    if (clear) begin
      pos_d     = '0;
      err_cnt_d = '0;
    end else begin
      if (step_up_d)
        pos_d = pos_q + POS_W'(1);
      else if (step_dn_d)
        pos_d = pos_q - POS_W'(1);
      if (err_d && (err_cnt_q != {ERR_W{1'b1}}))
        err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= UNPRIMED;
      bin_q       <= '0;
      out_valid_q <= 1'b0;
      step_up_q   <= 1'b0;
      step_dn_q   <= 1'b0;
      err_q       <= 1'b0;
      pos_q       <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      out_valid_q <= out_valid_d;
      step_up_q   <= step_up_d;
      step_dn_q   <= step_dn_d;
      err_q       <= err_d;
      pos_q       <= pos_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bin_out   = bin_q;
  assign out_valid = out_valid_q;
  assign step_up   = step_up_q;
  assign step_dn   = step_dn_q;
  assign err       = err_q;
  assign primed    = (state_q == TRACK);
  assign position  = pos_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_gray_track.sv
// Directed scenarios plus random traffic for gray_track, checked every cycle against
// an arithmetic model of the step/error rules.
module tb_gray_track;

  logic        clk = 1'b0;
  logic        rst, in_valid, clear;
  logic [3:0]  gray_in;
  logic [3:0]  bin_out;
  logic        out_valid, step_up, step_dn, err, primed;
  logic [15:0] position;
  logic [7:0]  err_count;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_prev, m_primed, m_pos, m_ec;
  int m_ov, m_up, m_dn, m_err;
  int cur_bin;

  gray_track dut (
    .clk(clk), .rst(rst), .gray_in(gray_in), .in_valid(in_valid), .clear(clear),
    .bin_out(bin_out), .out_valid(out_valid), .step_up(step_up), .step_dn(step_dn),
    .err(err), .primed(primed), .position(position), .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] to_gray(int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic int from_gray(logic [3:0] g);
    for (int i = 0; i < 16; i++)
      if (to_gray(i) == g) return i;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_edge(input int r, input int v, input int c, input int b);
    int d;
    m_ov = 0; m_up = 0; m_dn = 0; m_err = 0;
    if (r != 0) begin
      m_prev = 0; m_primed = 0; m_pos = 0; m_ec = 0;
      return;
    end
    if (v != 0) begin
      m_ov = 1;
      if (m_primed != 0) begin
        d = (b - m_prev + 16) % 16;
        if (d == 1) m_up = 1;
        else if (d == 15) m_dn = 1;
        else if (d != 0) m_err = 1;
      end
      m_prev = b;
      m_primed = 1;
    end
    if (c != 0) begin
      m_pos = 0; m_ec = 0;
    end else begin
      m_pos = (m_pos + m_up - m_dn + 65536) % 65536;
      if (m_err != 0 && m_ec < 255) m_ec++;
    end
  endtask

  // Apply one cycle of stimulus, advance the model and compare every output.
  task automatic cyc(input int r, input int v, input int c, input int b);
    rst = (r != 0); in_valid = (v != 0); clear = (c != 0); gray_in = to_gray(b);
    @(posedge clk);
    #1;
    model_edge(r, v, c, from_gray(to_gray(b)));
    check("bin_out",   32'(bin_out),   32'(m_prev));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("step_up",   32'(step_up),   32'(m_up));
    check("step_dn",   32'(step_dn),   32'(m_dn));
    check("err",       32'(err),       32'(m_err));
    check("primed",    32'(primed),    32'(m_primed));
    check("position",  32'(position),  32'(m_pos));
    check("err_count", 32'(err_count), 32'(m_ec));
    $display("t=%0t rst=%0d v=%0d clr=%0d g=%b -> bin=%0d ov=%0d up=%0d dn=%0d err=%0d pr=%0d pos=%0d ec=%0d",
             $time, r, v, c, to_gray(b), bin_out, out_valid, step_up, step_dn, err,
             primed, position, err_count);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; clear = 1'b0; gray_in = '0;
    m_prev = 0; m_primed = 0; m_pos = 0; m_ec = 0;
    m_ov = 0; m_up = 0; m_dn = 0; m_err = 0;

    // 1: reset state, then counting 0,1,2
    cyc(1, 0, 0, 0);
    check("reset_primed", 32'(primed), 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 1);
    cyc(0, 1, 0, 2);
    check("t1_position", 32'(position), 2);
    check("t1_bin", 32'(bin_out), 2);

    // 2: wrap in both directions
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 15);
    cyc(0, 1, 0, 0);
    check("t2_wrap_up", 32'(step_up), 1);
    cyc(0, 1, 0, 15);
    check("t2_wrap_dn", 32'(step_dn), 1);
    check("t2_position", 32'(position), 0);

    // 3: illegal jump then resync
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 2);
    check("t3_err", 32'(err), 1);
    check("t3_err_count", 32'(err_count), 1);
    cyc(0, 1, 0, 3);
    check("t3_resync_up", 32'(step_up), 1);

    // 4: error counter saturation
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 300; i++) cyc(0, 1, 0, (i % 2 == 0) ? 0 : 2);
    check("t4_sat", 32'(err_count), 255);
    check("t4_position", 32'(position), 0);

    // 5: clear alongside a step_up sample
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 4);
    cyc(0, 1, 0, 5);
    cyc(0, 1, 0, 9);
    cyc(0, 1, 1, 10);
    check("t5_up_pulse", 32'(step_up), 1);
    check("t5_pos_clr", 32'(position), 0);
    check("t5_ec_clr", 32'(err_count), 0);
    check("t5_primed", 32'(primed), 1);

    // 6: reset mid-stream with valid high
    cyc(0, 1, 0, 11);
    cyc(1, 1, 0, 12);
    check("t6_primed", 32'(primed), 0);
    check("t6_bin", 32'(bin_out), 0);
    cyc(0, 1, 0, 7);
    check("t6_first_ov", 32'(out_valid), 1);
    check("t6_first_noerr", 32'(err), 0);

    // random traffic, biased toward legal steps
    cur_bin = 7;
    for (int i = 0; i < 600; i++) begin
      int sel, r, v, c;
      sel = int'($urandom_range(0, 9));
      if (sel < 4)      cur_bin = (cur_bin + 1) % 16;
      else if (sel < 7) cur_bin = (cur_bin + 15) % 16;
      else if (sel > 7) cur_bin = int'($urandom_range(0, 15));
      r = ($urandom_range(0, 99) < 2) ? 1 : 0;
      c = ($urandom_range(0, 99) < 4) ? 1 : 0;
      v = ($urandom_range(0, 99) < 80) ? 1 : 0;
      cyc(r, v, c, cur_bin);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
